// File: rtl/fix_pkg.sv
// Shared fixed-point types and helpers for the complex arithmetic blocks.
// Holds the accumulator state encoding and the generic saturating clamp.
package fix_pkg;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} c_acc_state_t;

   localparam int SAT_W = 64;

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [SAT_W-1:0] fix_sat(
      input logic signed [SAT_W-1:0] value,
      input int width
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi)
         fix_sat = hi;
      else if (value < lo)
         fix_sat = lo;
      else
         fix_sat = value;
   endfunction

endpackage

// File: rtl/fix_shift_sat.sv
// Combinational arithmetic right shift followed by an optional clamp.
// Shifts at or beyond the input width fill with the sign bit.
module fix_shift_sat
   import fix_pkg::*;
#(
   parameter int IN_WIDTH  = 22,
   parameter int OUT_WIDTH = 16,
   parameter int SAT_EN    = 1,
   localparam int SH_WIDTH = $clog2(IN_WIDTH + 1)
) (
   input  logic signed [IN_WIDTH-1:0]  din,
   input  logic [SH_WIDTH-1:0]         shift,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        sat
);

   logic signed [IN_WIDTH-1:0] shifted;

   assign shifted = din >>> shift;

   generate
      if (SAT_EN != 0) begin : g_sat
         logic signed [SAT_W-1:0] wide;
         logic signed [SAT_W-1:0] clamped;
         assign wide    = {{(SAT_W-IN_WIDTH){shifted[IN_WIDTH-1]}}, shifted};
         assign clamped = fix_sat(wide, OUT_WIDTH);
         assign dout    = clamped[OUT_WIDTH-1:0];
         assign sat     = (clamped != wide);
      end else begin : g_wrap
         assign dout = shifted[OUT_WIDTH-1:0];
         assign sat  = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/fix_c_acc.sv
// Complex accumulate-and-dump: sums a frame of products, then emits one
// shifted and saturated result through a valid/ready output register.
module fix_c_acc
   import fix_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 16,
   parameter int MAX_LEN   = 64,
   parameter int SAT_EN    = 1,
   localparam int ACC_WIDTH = IN_WIDTH + $clog2(MAX_LEN),
   localparam int SH_WIDTH  = $clog2(ACC_WIDTH + 1),
   localparam int LEN_WIDTH = $clog2(MAX_LEN + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [IN_WIDTH-1:0]  in_R,
   input  logic signed [IN_WIDTH-1:0]  in_I,
   input  logic                        in_last,
   input  logic [SH_WIDTH-1:0]         shift_amount,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] out_R,
   output logic signed [OUT_WIDTH-1:0] out_I,
   output logic                        out_sat,
   output logic                        out_trunc,
   output logic [LEN_WIDTH-1:0]        out_len
);

   c_acc_state_t state;
   c_acc_state_t state_nxt;

   logic signed [ACC_WIDTH-1:0] acc_R;
   logic signed [ACC_WIDTH-1:0] acc_I;
   logic signed [ACC_WIDTH-1:0] sum_R;
   logic signed [ACC_WIDTH-1:0] sum_I;
   logic signed [ACC_WIDTH-1:0] ext_R;
   logic signed [ACC_WIDTH-1:0] ext_I;
   logic [LEN_WIDTH-1:0]        cnt;
   logic [LEN_WIDTH-1:0]        cnt_nxt;

   logic fire;
   logic pop;
   logic start;
   logic close;

   logic signed [OUT_WIDTH-1:0] res_R;
   logic signed [OUT_WIDTH-1:0] res_I;
   logic                        sat_R;
   logic                        sat_I;

   assign out_valid = (state == HOLD);
   assign in_ready  = (state != HOLD) | out_ready;
   assign fire      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // A fire outside ACC always opens a fresh frame (HOLD implies a pop).
   assign start   = fire & (state != ACC);
   assign ext_R   = {{(ACC_WIDTH-IN_WIDTH){in_R[IN_WIDTH-1]}}, in_R};
   assign ext_I   = {{(ACC_WIDTH-IN_WIDTH){in_I[IN_WIDTH-1]}}, in_I};
   assign sum_R   = (start ? '0 : acc_R) + ext_R;
   assign sum_I   = (start ? '0 : acc_I) + ext_I;
   assign cnt_nxt = start ? LEN_WIDTH'(1) : cnt + LEN_WIDTH'(1);
   assign close   = fire & (in_last | (cnt_nxt == LEN_WIDTH'(MAX_LEN)));

   fix_shift_sat #(
      .IN_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SAT_EN    (SAT_EN)
   ) u_ss_R (
      .din   (sum_R),
      .shift (shift_amount),
      .dout  (res_R),
      .sat   (sat_R)
   );

   fix_shift_sat #(
      .IN_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SAT_EN    (SAT_EN)
   ) u_ss_I (
      .din   (sum_I),
      .shift (shift_amount),
      .dout  (res_I),
      .sat   (sat_I)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (close)
         state_nxt = HOLD;
      else if (fire)
         state_nxt = ACC;
      else if (pop)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_R     <= '0;
         acc_I     <= '0;
         cnt       <= '0;
         out_R     <= '0;
         out_I     <= '0;
         out_sat   <= 1'b0;
         out_trunc <= 1'b0;
         out_len   <= '0;
      end else begin
         if (fire) begin
            acc_R <= sum_R;
            acc_I <= sum_I;
            cnt   <= cnt_nxt;
         end
         if (close) begin
            out_R     <= res_R;
            out_I     <= res_I;
            out_sat   <= sat_R | sat_I;
            out_trunc <= ~in_last;
            out_len   <= cnt_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fix_c_acc.sv
// Randomised scoreboard bench for fix_c_acc: the driver predicts each frame
// result from plain sums; a monitor compares whenever a result is presented.
module tb_fix_c_acc;

   localparam int MAX_LEN = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_R;
   logic signed [15:0] in_I;
   logic               in_last;
   logic [4:0]         shift_amount;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_R;
   logic signed [15:0] out_I;
   logic               out_sat;
   logic               out_trunc;
   logic [6:0]         out_len;

   int checks = 0;
   int errors = 0;
   bit rnd_mode = 1'b0;

   typedef struct {
      logic signed [15:0] r;
      logic signed [15:0] i;
      logic               sat;
      logic               trunc;
      logic [6:0]         len;
   } exp_t;

   exp_t   q[$];
   longint fr[$];
   longint fi[$];

   fix_c_acc dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_R         (in_R),
      .in_I         (in_I),
      .in_last      (in_last),
      .shift_amount (shift_amount),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_R        (out_R),
      .out_I        (out_I),
      .out_sat      (out_sat),
      .out_trunc    (out_trunc),
      .out_len      (out_len)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   function automatic longint clamp16(input longint v, output bit s);
      s = 1'b0;
      if (v > 32767) begin
         s = 1'b1;
         return 32767;
      end
      if (v < -32768) begin
         s = 1'b1;
         return -32768;
      end
      return v;
   endfunction

   // Reference: a frame is a list of samples; its result is their plain sum.
   task automatic model_accept(input int r, input int i, input bit last,
                               input int sh);
      longint sr;
      longint si;
      bit     s1;
      bit     s2;
      exp_t   e;
      fr.push_back(longint'(r));
      fi.push_back(longint'(i));
      if (last || fr.size() == MAX_LEN) begin
         sr = 0;
         si = 0;
         foreach (fr[k]) begin
            sr += fr[k];
            si += fi[k];
         end
         sr = sr >>> sh;
         si = si >>> sh;
         e.r     = 16'(clamp16(sr, s1));
         e.i     = 16'(clamp16(si, s2));
         e.sat   = s1 | s2;
         e.trunc = !last;
         e.len   = 7'(fr.size());
         q.push_back(e);
         fr.delete();
         fi.delete();
      end
   endtask

   task automatic check(input string name, input longint act,
                        input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic send(input int r, input int i, input bit last,
                       input int sh);
      int t;
      bit done;
      in_valid     = 1'b1;
      in_R         = r[15:0];
      in_I         = i[15:0];
      in_last      = last;
      shift_amount = sh[4:0];
      t    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(r, i, last, sh);
            done = 1'b1;
         end else if (t > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept");
            done = 1'b1;
         end
         t++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      fr.delete();
      fi.delete();
      q.delete();
      idle(2);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result actual=(%0d,%0d) required=none",
                     out_R, out_I);
         end else begin
            if (out_R !== q[0].r || out_I !== q[0].i ||
                out_sat !== q[0].sat || out_trunc !== q[0].trunc ||
                out_len !== q[0].len) begin
               errors++;
               $display("FAIL result actual=(%0d,%0d,s%0b,t%0b,n%0d) required=(%0d,%0d,s%0b,t%0b,n%0d)",
                        out_R, out_I, out_sat, out_trunc, out_len,
                        q[0].r, q[0].i, q[0].sat, q[0].trunc, q[0].len);
            end
            if (out_ready)
               void'(q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_mode) begin
         #1;
         out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_R = '0;
      in_I = '0;
      in_last = 1'b0;
      shift_amount = '0;
      out_ready = 1'b1;
      idle(1);
      do_reset();

      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_R", out_R, 0);
      check("rst_out_I", out_I, 0);
      check("rst_flags", {out_sat, out_trunc}, 0);
      check("rst_len", out_len, 0);
      @(posedge clk);
      #1;

      // 4-sample frame, result one clock after the last fire
      for (int k = 0; k < 4; k++)
         send(100, -50, k == 3, 0);
      check("latency_valid", out_valid, 1);
      idle(2);

      // Saturation, then same frame scaled down without clamping
      for (int k = 0; k < 8; k++)
         send(32767, -32768, k == 7, 0);
      idle(1);
      for (int k = 0; k < 8; k++)
         send(32767, -32768, k == 7, 3);
      idle(2);

      // Force-close at MAX_LEN, then the next sample opens a new frame
      for (int k = 0; k < MAX_LEN; k++)
         send(1, 1, 1'b0, 0);
      send(2, 3, 1'b1, 0);
      idle(2);

      // Backpressure in HOLD, then pop and new frame on the same edge
      out_ready = 1'b0;
      send(3, 4, 1'b0, 0);
      send(5, 6, 1'b1, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(10, 20, 1'b0, 0);
      send(30, 40, 1'b1, 0);
      idle(2);

      // Back-to-back single-sample frames at full rate
      for (int k = 1; k <= 8; k++) begin
         send(k, -k, 1'b1, 0);
         check("b2b_valid", out_valid, 1);
      end
      idle(2);

      // Large shift gives sign fill
      send(-5, 5, 1'b1, 31);
      idle(2);

      // Reset mid-frame discards the partial sums
      send(1000, 1000, 1'b0, 0);
      send(1000, 1000, 1'b0, 0);
      send(1000, 1000, 1'b0, 0);
      do_reset();
      send(5, 5, 1'b0, 0);
      send(7, 7, 1'b1, 0);
      idle(2);

      // Random frames with random backpressure and gaps
      rnd_mode = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         logic [15:0] rv;
         logic [15:0] iv;
         int r;
         int i;
         rv = 16'($urandom);
         iv = 16'($urandom);
         r = $signed(rv);
         i = $signed(iv);
         if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 3));
         send(r, i, $urandom_range(0, 9) == 0, $urandom_range(0, 31));
      end
      rnd_mode = 1'b0;
      idle(1);
      out_ready = 1'b1;
      idle(4);
      check("drain_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
